// File: rtl/window_pkg.sv
// Shared types and constants for the 3x3 streaming window generator.
package window_pkg;

  localparam int unsigned WIN_K          = 3;
  localparam int unsigned DEF_IMG_WIDTH  = 224;
  localparam int unsigned DEF_IMG_HEIGHT = 224;
  localparam int unsigned X_W            = $clog2(DEF_IMG_WIDTH);
  localparam int unsigned Y_W            = $clog2(DEF_IMG_HEIGHT);

  typedef enum logic [0:0] {
    StWaitSof,
    StActive
  } state_e;

  // Flat index of window element (row r, column c); r=0 is the top row, c=0 the left column.
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
    return r * WIN_K + c;
  endfunction

endpackage

// File: rtl/line_ram.sv
// One row of pixels: asynchronous read, synchronous write, contents not reset.
module line_ram #(
  parameter int unsigned DEPTH = 224,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; reading the same address in the same cycle returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/window3x3_stream.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 column shift array,
// emitting one window per interior pixel with the centre coordinates.
module window3x3_stream
  import window_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int unsigned PIX_W      = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [PIX_W-1:0]                 in_data,
  input  logic                             in_valid,
  input  logic                             in_sof,
  output logic                             in_ready,
  output logic [WIN_K*WIN_K*PIX_W-1:0]     win,
  output logic [$clog2(IMG_WIDTH)-1:0]     out_x,
  output logic [$clog2(IMG_HEIGHT)-1:0]    out_y,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             frame_done,
  output logic                             frame_err
);

  localparam int unsigned XW = $clog2(IMG_WIDTH);
  localparam int unsigned YW = $clog2(IMG_HEIGHT);

  state_e                        state_q, state_d;
  logic [XW-1:0]                 x_q, x_d, cur_x;
  logic [YW-1:0]                 y_q, y_d, cur_y;
  logic                          accept, take, row_end, last_px, emit, err_d;
  logic [PIX_W-1:0]              lb0_rd, lb1_rd;
  logic [PIX_W-1:0]              col_q [WIN_K][WIN_K];
  logic [PIX_W-1:0]              col_d [WIN_K][WIN_K];
  logic [WIN_K*WIN_K*PIX_W-1:0]  win_d, win_q;
  logic [XW-1:0]                 out_x_q;
  logic [YW-1:0]                 out_y_q;
  logic                          out_valid_q, done_q, err_q;

  // Handshake and FSM outputs; a sof pixel is always placed at (0,0).
  always_comb begin
    in_ready = ~out_valid_q | out_ready;
    accept   = in_valid & in_ready;
    take     = accept & (in_sof | (state_q == StActive));
    cur_x    = in_sof ? '0 : x_q;
    cur_y    = in_sof ? '0 : y_q;
    err_d    = accept & in_sof & (state_q == StActive) & ((x_q != '0) | (y_q != '0));
    row_end  = (cur_x == XW'(IMG_WIDTH - 1));
    last_px  = row_end & (cur_y == YW'(IMG_HEIGHT - 1));
    emit     = take & (cur_x >= XW'(2)) & (cur_y >= YW'(2));
  end

  // Next state and raster position.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    if (take) begin
      if (last_px) begin
        state_d = StWaitSof;
        x_d     = '0;
        y_d     = '0;
      end else begin
        state_d = StActive;
        if (row_end) begin
          x_d = '0;
          y_d = cur_y + 1'b1;
        end else begin
          x_d = cur_x + 1'b1;
          y_d = cur_y;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWaitSof;
    end else begin
      state_q <= state_d;
    end
  end

  // Raster position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Rows y-2 and y-1: lb0 inherits lb1's old word as lb1 takes the new pixel.
  line_ram #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIX_W)
  ) u_lb0 (
    .clk   (clk),
    .we    (take),
    .addr  (cur_x),
    .wdata (lb1_rd),
    .rdata (lb0_rd)
  );

  line_ram #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIX_W)
  ) u_lb1 (
    .clk   (clk),
    .we    (take),
    .addr  (cur_x),
    .wdata (in_data),
    .rdata (lb1_rd)
  );

  // Shift columns left and load the new right column (top..bottom); sof clears history.
  always_comb begin
    for (int unsigned r = 0; r < WIN_K; r++) begin
      for (int unsigned c = 0; c < WIN_K; c++) begin
        col_d[r][c] = col_q[r][c];
      end
    end
    if (take) begin
      for (int unsigned r = 0; r < WIN_K; r++) begin
        for (int unsigned c = 0; c < WIN_K - 1; c++) begin
          col_d[r][c] = in_sof ? '0 : col_q[r][c+1];
        end
      end
      col_d[0][WIN_K-1] = lb0_rd;
      col_d[1][WIN_K-1] = lb1_rd;
      col_d[2][WIN_K-1] = in_data;
    end
  end

  // Flatten the next column array into the output window layout.
  always_comb begin
    win_d = '0;
    for (int unsigned r = 0; r < WIN_K; r++) begin
      for (int unsigned c = 0; c < WIN_K; c++) begin
        win_d[win_idx(r, c)*PIX_W +: PIX_W] = col_d[r][c];
      end
    end
  end

  // Column shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < WIN_K; r++) begin
        for (int unsigned c = 0; c < WIN_K; c++) begin
          col_q[r][c] <= '0;
        end
      end
    end else begin
      col_q <= col_d;
    end
  end

  // Output window register: loads on interior pixels, holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      win_q       <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (emit) begin
        out_valid_q <= 1'b1;
        win_q       <= win_d;
        out_x_q     <= cur_x - 1'b1;
        out_y_q     <= cur_y - 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      done_q <= take & last_px;
      err_q  <= err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign win        = win_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule
